// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg: shared event ids, de window bounds and the default event record.
package seq_mon_pkg;
    typedef enum logic [1:0] {
        EVT_ABC  = 2'b01,
        EVT_DE   = 2'b10,
        EVT_BOTH = 2'b11
    } evt_id_t;
    localparam int DE_MIN = 2;
    localparam int DE_MAX = 5;
    localparam int EVT_TS_W = 16;
    typedef struct packed {
        evt_id_t             id;
        logic [EVT_TS_W-1:0] ts;
    } evt_t;
endpackage

// File: rtl/seq_mon_fifo.sv
// seq_mon_fifo: wrap-bit pointer FIFO; a push on full succeeds only if a pop frees a slot that edge.
module seq_mon_fifo
    import seq_mon_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = evt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty,
    output logic drop
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW:0] wr, rd;
    logic do_push, do_pop;
    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = empty ? T'('0) : mem[rd[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/seq_event_monitor.sv
// seq_event_monitor: detects a ##1 b ##1 c and d ##[2:5] e, counts matches
// and queues timestamped event records behind a valid/ready handshake.
module seq_event_monitor
    import seq_mon_pkg::*;
#(
    parameter int TS_W       = 16,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             clr_cnt,
    output logic             abc_hit,
    output logic             de_hit,
    output logic [CNT_W-1:0] abc_cnt,
    output logic [CNT_W-1:0] de_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_id,
    output logic [TS_W-1:0]  evt_ts,
    output logic             overflow
);
    typedef struct packed {
        evt_id_t         id;
        logic [TS_W-1:0] ts;
    } rec_t;
    logic              a_d, ab_d;
    logic [DE_MAX-1:0] d_sh;
    logic [TS_W-1:0]   ts;
    logic              abc_m, de_m, full, empty, drop;
    rec_t              head, rec;
    // d_sh[i] holds d from i+1 edges ago, so the window k-2..k-5 is bits 1..4
    assign abc_m = ab_d & c & en;
    assign de_m  = e & en & |d_sh[DE_MAX-1:DE_MIN-1];
    assign rec   = '{id: evt_id_t'({de_m, abc_m}), ts: ts};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d      <= 1'b0;
            ab_d     <= 1'b0;
            d_sh     <= '0;
            ts       <= '0;
            abc_hit  <= 1'b0;
            de_hit   <= 1'b0;
            abc_cnt  <= '0;
            de_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            a_d      <= a & en;
            ab_d     <= a_d & b & en;
            d_sh     <= {d_sh[DE_MAX-2:0], d & en};
            ts       <= ts + 1'b1;
            abc_hit  <= abc_m;
            de_hit   <= de_m;
            abc_cnt  <= clr_cnt ? '0 : (abc_m && abc_cnt != '1) ? abc_cnt + 1'b1 : abc_cnt;
            de_cnt   <= clr_cnt ? '0 : (de_m && de_cnt != '1) ? de_cnt + 1'b1 : de_cnt;
            overflow <= overflow | drop;
        end
    end
    seq_mon_fifo #(.DEPTH(FIFO_DEPTH), .T(rec_t)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (abc_m | de_m),
        .pop  (evt_ready),
        .din  (rec),
        .dout (head),
        .full (full),
        .empty(empty),
        .drop (drop)
    );
    assign evt_valid = !empty;
    assign evt_id    = head.id;
    assign evt_ts    = head.ts;
endmodule

// File: tb/tb_seq_event_monitor.sv
// tb_seq_event_monitor: directed checks of both detectors, counters and event queue.
module tb_seq_event_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    logic clr_cnt = 1'b0, evt_ready = 1'b0;
    logic abc_hit, de_hit, evt_valid, overflow;
    logic [7:0] abc_cnt, de_cnt;
    logic [1:0] evt_id;
    logic [15:0] evt_ts;
    logic s_abc_hit, s_de_hit, s_evt_valid, s_overflow;
    logic [1:0] s_abc_cnt, s_de_cnt, s_evt_id;
    logic [15:0] s_evt_ts;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_event_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e),
        .clr_cnt(clr_cnt), .abc_hit(abc_hit), .de_hit(de_hit), .abc_cnt(abc_cnt),
        .de_cnt(de_cnt), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_ts(evt_ts), .overflow(overflow)
    );

    seq_event_monitor #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e),
        .clr_cnt(clr_cnt), .abc_hit(s_abc_hit), .de_hit(s_de_hit), .abc_cnt(s_abc_cnt),
        .de_cnt(s_de_cnt), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
        .evt_id(s_evt_id), .evt_ts(s_evt_ts), .overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [4:0] v);
        {a, b, c, d, e} = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {a, b, c, d, e} = '0;
        en = 1'b1;
        clr_cnt = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_ts[3] = '{34, 36, 39};
        // abc single match
        do_reset();
        check("rst_abc_hit", abc_hit, 0);
        check("rst_de_hit", de_hit, 0);
        check("rst_abc_cnt", abc_cnt, 0);
        check("rst_de_cnt", de_cnt, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_id", evt_id, 0);
        check("rst_ts", evt_ts, 0);
        check("rst_overflow", overflow, 0);
        evt_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            cyc(k == 3 ? 5'b10000 : k == 4 ? 5'b01000 : k == 5 ? 5'b00100 : 5'b0);
            check($sformatf("t1_abc_hit_k%0d", k), abc_hit, k == 5);
            check($sformatf("t1_de_hit_k%0d", k), de_hit, 0);
        end
        check("t1_abc_cnt", abc_cnt, 1);
        check("t1_valid", evt_valid, 1);
        check("t1_id", evt_id, 1);
        check("t1_ts", evt_ts, 5);
        cyc(5'b0);
        check("t1_valid_after_pop", evt_valid, 0);
        check("t1_de_cnt", de_cnt, 0);

        // de window: d@10, e on 11..16
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            cyc({3'b0, k == 10, k >= 11});
            check($sformatf("t2_de_hit_k%0d", k), de_hit, k >= 12 && k <= 15);
        end
        check("t2_de_cnt", de_cnt, 4);
        check("t2_abc_cnt", abc_cnt, 0);
        check("t2_overflow", overflow, 0);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_valid_%0d", i), evt_valid, 1);
            check($sformatf("t2_id_%0d", i), evt_id, 2);
            check($sformatf("t2_ts_%0d", i), evt_ts, 12 + i);
            cyc(5'b0);
        end
        check("t2_drained", evt_valid, 0);

        // overlapping abc, saturation, clear priority, enable gating
        do_reset();
        evt_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            cyc(5'b11100);
            check($sformatf("t3_abc_hit_k%0d", k), abc_hit, k >= 2);
            if (k == 4) begin
                check("t3_cnt3", abc_cnt, 3);
                check("t3_sat_cnt3", s_abc_cnt, 3);
            end
        end
        check("t3_cnt5", abc_cnt, 5);
        check("t3_sat_hold", s_abc_cnt, 3);
        clr_cnt = 1'b1;
        cyc(5'b11100);
        clr_cnt = 1'b0;
        check("t3_clr_hit", abc_hit, 1);
        check("t3_clr_cnt", abc_cnt, 0);
        check("t3_clr_sat_cnt", s_abc_cnt, 0);
        en = 1'b0;
        cyc(5'b11100);
        check("t3_en0_hit_k8", abc_hit, 0);
        cyc(5'b11100);
        check("t3_en0_hit_k9", abc_hit, 0);
        check("t3_en0_cnt", abc_cnt, 0);
        en = 1'b1;
        cyc(5'b11100);
        check("t3_en1_hit_k10", abc_hit, 0);
        cyc(5'b11100);
        check("t3_en1_hit_k11", abc_hit, 0);
        cyc(5'b11100);
        check("t3_en1_hit_k12", abc_hit, 1);
        check("t3_en1_cnt", abc_cnt, 1);
        check("t3_ts_running", evt_ts, 12);

        // simultaneous abc and de at edge 20
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k <= 20; k++)
            cyc({k == 18, k == 19, k == 20, k == 15, k == 20});
        check("t4_abc_hit", abc_hit, 1);
        check("t4_de_hit", de_hit, 1);
        check("t4_abc_cnt", abc_cnt, 1);
        check("t4_de_cnt", de_cnt, 1);
        check("t4_valid", evt_valid, 1);
        check("t4_id", evt_id, 3);
        check("t4_ts", evt_ts, 20);
        evt_ready = 1'b1;
        cyc(5'b0);
        check("t4_single_entry", evt_valid, 0);

        // overflow, then push on full with simultaneous pop
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k <= 38; k++) begin
            cyc({3'b0, k <= 36, k >= 30 && k % 2 == 0});
            if (k == 36) check("t5_no_ovf_yet", overflow, 0);
        end
        check("t5_overflow", overflow, 1);
        check("t5_de_cnt", de_cnt, 5);
        check("t5_head_ts", evt_ts, 30);
        evt_ready = 1'b1;
        cyc(5'b00001);
        check("t5_full_pushpop_hit", de_hit, 1);
        check("t5_full_pushpop_cnt", de_cnt, 6);
        check("t5_head_ts32", evt_ts, 32);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b0);
            check($sformatf("t5_valid_%0d", i), evt_valid, 1);
            check($sformatf("t5_ts_%0d", i), evt_ts, exp_ts[i]);
        end
        cyc(5'b0);
        check("t5_drained", evt_valid, 0);
        check("t5_ovf_sticky", overflow, 1);

        // reset in the middle of an abc attempt
        cyc(5'b10000);
        cyc(5'b01000);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_de_cnt", de_cnt, 0);
        check("t6_async_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5'b00100);
        check("t6_abc_hit", abc_hit, 0);
        check("t6_abc_cnt", abc_cnt, 0);
        check("t6_valid", evt_valid, 0);
        check("t6_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
